gray_ptr_ctrl: RTL

Parametrised FIFO pointer controller that holds one side's pointer as a binary counter, publishes it as a registered Gray-coded pointer, and derives a registered full or empty flag plus fill level from the opposite side's Gray pointer. One instance sits on the write side (full flag) and one on the read side (empty flag) of the FIFO. It generalises plain binary-to-Gray conversion with a wrap bit, inc gating, Gray-to-binary decode of the remote pointer, and flag/level generation.

---
 rtl/gray_ptr_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/gray_ptr_ctrl.sv
// gray_ptr_ctrl: one side of an async FIFO pointer pair.
// Keeps a binary pointer, publishes a registered Gray pointer, and derives
// a registered full (MODE 0) or empty (MODE 1) flag and fill level from the
// opposite side's synchronised Gray pointer.
// Optional feature: define GRAY_PTR_ALMOST_EN to add the registered almost flag.
module gray_ptr_ctrl #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned MODE      = 0,
  parameter int unsigned ALMOST_TH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic [ADDR_W:0]   remote_gray,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   ptr_gray,
  output logic              flag,
  output logic [ADDR_W:0]   level
`ifdef GRAY_PTR_ALMOST_EN
  ,
  output logic              almost
`endif
);

  // Full test inverts the top two Gray bits of the remote pointer; for
  // ADDR_W=1 this shift covers both bits of the 2-bit pointer.
  localparam logic [ADDR_W:0] TWO_ONES  = (ADDR_W+1)'(2'b11);
  localparam logic [ADDR_W:0] FULL_MASK = TWO_ONES << (ADDR_W - 1);

  logic [ADDR_W:0] bin;
  logic [ADDR_W:0] bin_next;
  logic [ADDR_W:0] gray_next;
  logic [ADDR_W:0] remote_bin;
  logic [ADDR_W:0] level_next;
  logic            advance;
  logic            flag_next;

  assign addr = bin[ADDR_W-1:0];

  // Next pointer, remote decode, flag and level evaluation
  always_comb begin
    advance    = inc & ~flag;
    bin_next   = bin + {{ADDR_W{1'b0}}, advance};
    gray_next  = bin_next ^ (bin_next >> 1);
    remote_bin = '0;
    remote_bin[ADDR_W] = remote_gray[ADDR_W];
    for (int unsigned i = 1; i <= ADDR_W; i++) begin
      remote_bin[ADDR_W-i] = remote_bin[ADDR_W-i+1] ^ remote_gray[ADDR_W-i];
    end
    if (MODE == 0) begin
      flag_next  = (gray_next == (remote_gray ^ FULL_MASK));
      level_next = bin_next - remote_bin;
    end else begin
      flag_next  = (gray_next == remote_gray);
      level_next = remote_bin - bin_next;
    end
  end

  // Pointer, Gray export, flag and level registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bin      <= '0;
      ptr_gray <= '0;
      level    <= '0;
      flag     <= (MODE != 0);
    end else begin
      bin      <= bin_next;
      ptr_gray <= gray_next;
      level    <= level_next;
      flag     <= flag_next;
    end
  end

`ifdef GRAY_PTR_ALMOST_EN
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic almost_next;

  // Almost-full / almost-empty threshold against the next level
  always_comb begin
    if (MODE == 0) begin
      almost_next = (32'(level_next) >= (DEPTH - ALMOST_TH));
    end else begin
      almost_next = (32'(level_next) <= ALMOST_TH);
    end
  end

  // Almost flag register, same latency as flag
  always_ff @(posedge clk) begin
    if (rst) begin
      almost <= (MODE != 0);
    end else begin
      almost <= almost_next;
    end
  end
`endif

endmodule
